// File: rtl/cndm_proto_tx_sched.sv
// ============================================================================
// Module   : cndm_proto_tx_sched
// Purpose  : Round-robin TX descriptor-fetch scheduler with an in-flight
//            credit limit.
// Options  : CNDM_PROTO_TX_SCHED_STATS_EN adds request/stall counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cndm_proto_tx_sched #(
  parameter int QUEUES       = 4,
  parameter int PTR_W        = 16,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [QUEUES-1:0]           q_en,
  input  logic [QUEUES*PTR_W-1:0]     q_prod,
  input  logic [QUEUES*PTR_W-1:0]     q_cons,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [$clog2(QUEUES)-1:0]   req_queue,
  input  logic                        cpl_valid,
  output logic [3:0]                  inflight,
  output logic                        busy
`ifdef CNDM_PROTO_TX_SCHED_STATS_EN
  ,
  output logic [31:0]                 stat_req_count,
  output logic [31:0]                 stat_stall_count
`endif
);

  localparam int QW = $clog2(QUEUES);
  localparam logic [3:0]    MAX_INF = 4'(MAX_INFLIGHT);
  localparam logic [QW-1:0] LAST_Q  = QW'(QUEUES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    sched_ptr_q [QUEUES];
  logic [PTR_W-1:0]    sched_ptr_d [QUEUES];
  logic [QW-1:0]       last_grant_q, last_grant_d;
  logic [QW-1:0]       req_queue_q, req_queue_d;
  logic                req_valid_q, req_valid_d;
  logic [3:0]          inflight_q, inflight_d;

  logic                accept;
  logic [QUEUES-1:0]   elig_cur;
  logic [QUEUES-1:0]   elig_post;
  logic                rr_found;
  logic [QW-1:0]       rr_sel;
  logic [QW-1:0]       rr_idx;

  assign accept = req_valid_q && req_ready;

  // Simultaneous grant and completion cancel; completions never underflow.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !cpl_valid) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!accept && cpl_valid && (inflight_q != 4'd0)) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  // A disabled queue follows its consumer pointer, overriding any grant.
  always_comb begin
    for (int i = 0; i < QUEUES; i++) begin
      if (!q_en[i]) begin
        sched_ptr_d[i] = q_cons[i*PTR_W +: PTR_W];
      end else if (accept && (req_queue_q == QW'(i))) begin
        sched_ptr_d[i] = sched_ptr_q[i] + PTR_W'(1);
      end else begin
        sched_ptr_d[i] = sched_ptr_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < QUEUES; i++) begin
      elig_cur[i]  = q_en[i] && (sched_ptr_q[i] != q_prod[i*PTR_W +: PTR_W])
                     && (inflight_q < MAX_INF);
      elig_post[i] = q_en[i] && (sched_ptr_d[i] != q_prod[i*PTR_W +: PTR_W])
                     && (inflight_d < MAX_INF);
    end
  end

  // Search starts one past the last grant and wraps around the queue set.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = '0;
    for (int k = 0; k < QUEUES; k++) begin
      rr_idx = QW'((int'(last_grant_q) + 1 + k) % QUEUES);
      if (!rr_found && elig_cur[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    req_queue_d  = req_queue_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|elig_cur) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (rr_found) begin
          req_valid_d = 1'b1;
          req_queue_d = rr_sel;
          state_d     = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (accept) begin
          req_valid_d  = 1'b0;
          last_grant_d = req_queue_q;
          state_d      = (|elig_post) ? ARB : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_queue_q  <= '0;
      last_grant_q <= LAST_Q;
      inflight_q   <= 4'd0;
      for (int i = 0; i < QUEUES; i++) begin
        sched_ptr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_queue_q  <= req_queue_d;
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
      for (int i = 0; i < QUEUES; i++) begin
        sched_ptr_q[i] <= sched_ptr_d[i];
      end
    end
  end

  assign req_valid = req_valid_q;
  assign req_queue = req_queue_q;
  assign inflight  = inflight_q;
  assign busy      = req_valid_q || (inflight_q != 4'd0);

`ifdef CNDM_PROTO_TX_SCHED_STATS_EN
  logic [31:0] stat_req_count_q, stat_req_count_d;
  logic [31:0] stat_stall_count_q, stat_stall_count_d;

  always_comb begin
    stat_req_count_d   = stat_req_count_q + 32'(accept);
    stat_stall_count_d = stat_stall_count_q + 32'(req_valid_q && !req_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_req_count_q   <= 32'd0;
      stat_stall_count_q <= 32'd0;
    end else begin
      stat_req_count_q   <= stat_req_count_d;
      stat_stall_count_q <= stat_stall_count_d;
    end
  end

  assign stat_req_count   = stat_req_count_q;
  assign stat_stall_count = stat_stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cndm_proto_tx_sched.sv
// ============================================================================
// Module   : tb_cndm_proto_tx_sched
// Purpose  : Directed self-checking bench for cndm_proto_tx_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cndm_proto_tx_sched;

  localparam int QUEUES = 4;
  localparam int PTR_W  = 16;

  logic                    clk;
  logic                    rst_n;
  logic [QUEUES-1:0]       q_en;
  logic [QUEUES*PTR_W-1:0] q_prod;
  logic [QUEUES*PTR_W-1:0] q_cons;
  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_queue;
  logic                    cpl_valid;
  logic [3:0]              inflight;
  logic                    busy;
`ifdef CNDM_PROTO_TX_SCHED_STATS_EN
  logic [31:0]             stat_req_count;
  logic [31:0]             stat_stall_count;
`endif

  int total = 0;
  int bad   = 0;

  cndm_proto_tx_sched #(
    .QUEUES      (QUEUES),
    .PTR_W       (PTR_W),
    .MAX_INFLIGHT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q_en      (q_en),
    .q_prod    (q_prod),
    .q_cons    (q_cons),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_queue (req_queue),
    .cpl_valid (cpl_valid),
    .inflight  (inflight),
    .busy      (busy)
`ifdef CNDM_PROTO_TX_SCHED_STATS_EN
    ,
    .stat_req_count  (stat_req_count),
    .stat_stall_count(stat_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    q_en      = '0;
    q_prod    = '0;
    q_cons    = '0;
    req_ready = 1'b0;
    cpl_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (req_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, 32'(req_valid), 32'd1);
  endtask

  // Waits for a request, checks its queue, and accepts it on the next edge,
  // optionally returning a completion in that same cycle.
  task automatic grant(input string tag, input int exp_q, input bit cpl);
    wait_valid(tag);
    chk(tag, 32'(req_queue), 32'(exp_q));
    req_ready = 1'b1;
    cpl_valid = cpl;
    @(negedge clk);
    cpl_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    q_en      = '0;
    q_prod    = '0;
    q_cons    = '0;
    req_ready = 1'b0;
    cpl_valid = 1'b0;
    do_reset();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_queue", 32'(req_queue), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last_grant", 32'(dut.last_grant_q), 32'd3);

    // Completion with nothing outstanding is dropped.
    cpl_valid = 1'b1;
    @(negedge clk);
    cpl_valid = 1'b0;
    chk("cpl_sat_zero", 32'(inflight), 32'd0);

    // Single queue, three descriptors, with latency check.
    do_reset();
    req_ready = 1'b1;
    q_prod[0*PTR_W +: PTR_W] = 16'd3;
    q_en = 4'b0001;
    @(negedge clk);
    chk("lat_cycle1", 32'(req_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(req_valid), 32'd1);
    for (int i = 0; i < 3; i++) grant("single_q", 0, 1'b1);
    repeat (5) @(negedge clk);
    chk("single_idle", 32'(req_valid), 32'd0);
    chk("single_ptr", 32'(dut.sched_ptr_q[0]), 32'd3);
    chk("single_inflight", 32'(inflight), 32'd0);
    chk("single_busy", 32'(busy), 32'd0);

    // Round robin across all four queues.
    do_reset();
    req_ready = 1'b1;
    for (int i = 0; i < QUEUES; i++) q_prod[i*PTR_W +: PTR_W] = 16'd2;
    q_en = 4'b1111;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < QUEUES; i++) grant("rr_order", i, 1'b1);
    repeat (5) @(negedge clk);
    chk("rr_idle", 32'(req_valid), 32'd0);
    chk("rr_inflight", 32'(inflight), 32'd0);

    // Credit limit.
    do_reset();
    req_ready = 1'b1;
    q_prod[1*PTR_W +: PTR_W] = 16'd10;
    q_en = 4'b0010;
    for (int i = 0; i < 4; i++) grant("credit_q", 1, 1'b0);
    repeat (5) @(negedge clk);
    chk("credit_stall_valid", 32'(req_valid), 32'd0);
    chk("credit_inflight", 32'(inflight), 32'd4);
    chk("credit_busy", 32'(busy), 32'd1);
    cpl_valid = 1'b1;
    @(negedge clk);
    cpl_valid = 1'b0;
    chk("credit_after_cpl", 32'(inflight), 32'd3);
    grant("credit_extra", 1, 1'b0);
    repeat (5) @(negedge clk);
    chk("credit_one_more", 32'(req_valid), 32'd0);
    chk("credit_inflight2", 32'(inflight), 32'd4);

    // Backpressure holds the request stable.
    do_reset();
    q_prod[0*PTR_W +: PTR_W] = 16'd1;
    q_en = 4'b0001;
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(req_valid), 32'd1);
      chk("bp_queue", 32'(req_queue), 32'd0);
    end
`ifdef CNDM_PROTO_TX_SCHED_STATS_EN
    chk("stat_stall", stat_stall_count, 32'd5);
    chk("stat_req_before", stat_req_count, 32'd0);
`endif
    req_ready = 1'b1;
    @(negedge clk);
    chk("bp_accepted", 32'(req_valid), 32'd0);
    chk("bp_inflight", 32'(inflight), 32'd1);
`ifdef CNDM_PROTO_TX_SCHED_STATS_EN
    chk("stat_req_after", stat_req_count, 32'd1);
    chk("stat_stall_after", stat_stall_count, 32'd5);
`endif

    // Pointer wrap, then disable reloads from consumer pointer.
    do_reset();
    q_cons[2*PTR_W +: PTR_W] = 16'hFFFE;
    q_prod[2*PTR_W +: PTR_W] = 16'hFFFE;
    @(negedge clk);
    chk("wrap_preload", 32'(dut.sched_ptr_q[2]), 32'h0000FFFE);
    q_prod[2*PTR_W +: PTR_W] = 16'h0001;
    q_en = 4'b0100;
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) grant("wrap_q", 2, 1'b1);
    repeat (4) @(negedge clk);
    chk("wrap_idle", 32'(req_valid), 32'd0);
    chk("wrap_ptr", 32'(dut.sched_ptr_q[2]), 32'h00000001);
    q_en = 4'b0000;
    q_cons[2*PTR_W +: PTR_W] = 16'h0005;
    repeat (4) @(negedge clk);
    chk("disable_ptr", 32'(dut.sched_ptr_q[2]), 32'h00000005);
    chk("disable_no_req", 32'(req_valid), 32'd0);

    // Disable during a pending request: handshake completes, disable wins.
    do_reset();
    q_prod[3*PTR_W +: PTR_W] = 16'd4;
    q_en = 4'b1000;
    wait_valid("dis_req");
    q_en = 4'b0000;
    q_cons[3*PTR_W +: PTR_W] = 16'd7;
    repeat (2) @(negedge clk);
    chk("dis_hold_valid", 32'(req_valid), 32'd1);
    chk("dis_hold_queue", 32'(req_queue), 32'd3);
    req_ready = 1'b1;
    @(negedge clk);
    chk("dis_ptr", 32'(dut.sched_ptr_q[3]), 32'd7);
    chk("dis_inflight", 32'(inflight), 32'd1);
    repeat (4) @(negedge clk);
    chk("dis_no_more", 32'(req_valid), 32'd0);

    // Reset in the middle of a handshake.
    do_reset();
    req_ready = 1'b1;
    q_prod[0*PTR_W +: PTR_W] = 16'd10;
    q_en = 4'b0001;
    grant("mid_a", 0, 1'b0);
    grant("mid_b", 0, 1'b0);
    req_ready = 1'b0;
    wait_valid("mid_pend");
    chk("mid_pre_valid", 32'(req_valid), 32'd1);
    chk("mid_pre_inflight", 32'(inflight), 32'd2);
    rst_n = 1'b0;
    req_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(req_valid), 32'd0);
    chk("mid_rst_inflight", 32'(inflight), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    req_ready = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
